// File: rtl/bzone_noise_source_pkg.sv
// Shared constants and types for the BattleZone sound section.
// Holds the noise LFSR geometry, its step function and the default system clock.
package bzone_noise_source_pkg;

    localparam int LFSR_W = 17;
    localparam int TAP_HI = 16;
    localparam int TAP_LO = 13;

    // Default system clock shared by all sound stages.
    localparam int SND_CLK_HZ = 12_096_000;

    typedef logic [LFSR_W-1:0] lfsr_t;

    // One Fibonacci step of x^17 + x^14 + 1: shift left, feed back the tap XOR.
    function automatic lfsr_t lfsr_step(input lfsr_t cur);
        return {cur[LFSR_W-2:0], cur[TAP_HI] ^ cur[TAP_LO]};
    endfunction

endpackage

// File: rtl/bzone_noise_source_if.sv
// Control/observation bundle of the noise source.
// master drives noise_en/load/seed_in; slave (the block) drives strobes and LFSR state.
interface bzone_noise_source_if;
    import bzone_noise_source_pkg::*;

    logic  noise_en;
    logic  load;
    lfsr_t seed_in;
    logic  clk_12KHz_en;
    logic  clk_6KHz_en;
    logic  noise;
    lfsr_t lfsr;

    modport master (
        output noise_en, load, seed_in,
        input  clk_12KHz_en, clk_6KHz_en, noise, lfsr
    );

    modport slave (
        input  noise_en, load, seed_in,
        output clk_12KHz_en, clk_6KHz_en, noise, lfsr
    );

endinterface

// File: rtl/bzone_clk_en_div.sv
// Divide-by-DIV clock-enable generator with a half-rate companion strobe.
// Both strobes are registered, one cycle wide, and the slow one lands on every second fast one.
module bzone_clk_en_div #(
    parameter int DIV = 1008
) (
    input  logic clk,
    input  logic rst_n,
    output logic en_fast,
    output logic en_slow
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             ph;
    logic             wrap;

    assign wrap = (cnt == CNT_MAX);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values; mixing in = here would create order-dependent behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ph      <= 1'b0;
            en_fast <= 1'b0;
            en_slow <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + 1'b1;
            en_fast <= wrap;
            en_slow <= wrap && ph;
            // Phase flips once per fast strobe, so it is 1 before every even wrap.
            if (en_fast) begin
                ph <= ~ph;
            end
        end
    end

endmodule

// File: rtl/bzone_noise_source.sv
// 12/6 kHz enable generator plus 17-bit noise LFSR for the BattleZone sound section.
// Define NOISE_LOCKUP_GUARD_EN to reload SEED whenever a step is due from the all-zero state.
module bzone_noise_source
    import bzone_noise_source_pkg::*;
#(
    parameter int    CLK_HZ   = SND_CLK_HZ,
    parameter int    NOISE_HZ = 12_000,
    parameter lfsr_t SEED     = 17'h1FFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bzone_noise_source_if.slave   bus
);

    localparam int DIV = CLK_HZ / NOISE_HZ;

    logic  en_12k;
    logic  en_6k;
    lfsr_t lfsr_q;
    lfsr_t lfsr_next_step;
    logic  step_due;

    bzone_clk_en_div #(
        .DIV (DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_fast (en_12k),
        .en_slow (en_6k)
    );

    assign step_due = en_12k && bus.noise_en;

`ifdef NOISE_LOCKUP_GUARD_EN
    // All-zero is the one state the feedback can never leave; restart from SEED.
    assign lfsr_next_step = (lfsr_q == '0) ? SEED : lfsr_step(lfsr_q);
`else
    assign lfsr_next_step = lfsr_step(lfsr_q);
`endif

    // Load outranks a due step; the divider keeps running regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (bus.load) begin
            lfsr_q <= bus.seed_in;
        end else if (step_due) begin
            lfsr_q <= lfsr_next_step;
        end
    end

    assign bus.clk_12KHz_en = en_12k;
    assign bus.clk_6KHz_en  = en_6k;
    assign bus.lfsr         = lfsr_q;
    assign bus.noise        = lfsr_q[TAP_HI];

endmodule

// File: tb/tb_bzone_noise_source.sv
// Self-checking bench: default-rate instance with directed scenarios, fast-divider
// instance under random load/noise_en, both compared every cycle against a reference model.
module tb_bzone_noise_source;
    import bzone_noise_source_pkg::*;

    localparam int    DIV_A = 1008;
    localparam int    DIV_B = 3;
    localparam lfsr_t SEED  = 17'h1FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bzone_noise_source_if if_a ();
    bzone_noise_source_if if_b ();

    bzone_noise_source u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    bzone_noise_source #(
        .CLK_HZ   (12),
        .NOISE_HZ (4)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    // Reference state: edges since reset release and the expected register value.
    int    cyc_a = 0;
    int    cyc_b = 0;
    lfsr_t m_a = SEED;
    lfsr_t m_b = SEED;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit strobe_at(input int c, input int period);
        return (c > 0) && (c % period == 0);
    endfunction

    // x^17 + x^14 + 1 as arithmetic: double modulo 2^17, add the feedback bit.
    function automatic lfsr_t ref_step(input lfsr_t v);
        int unsigned dbl;
        int unsigned fb;
        dbl = (32'(v) * 2) % 131072;
        fb  = ((32'(v) >> 16) ^ (32'(v) >> 13)) & 1;
        return lfsr_t'(dbl + fb);
    endfunction

    function automatic lfsr_t ref_next(input lfsr_t v, input bit ld, input lfsr_t sd,
                                       input bit strobe, input bit en);
        if (ld) return sd;
        if (strobe && en) begin
`ifdef NOISE_LOCKUP_GUARD_EN
            if (v == 0) return SEED;
`endif
            return ref_step(v);
        end
        return v;
    endfunction

    task automatic compare_all();
        check("a_12k",   32'(if_a.clk_12KHz_en), 32'(strobe_at(cyc_a, DIV_A)));
        check("a_6k",    32'(if_a.clk_6KHz_en),  32'(strobe_at(cyc_a, 2 * DIV_A)));
        check("a_lfsr",  32'(if_a.lfsr),         32'(m_a));
        check("a_noise", 32'(if_a.noise),        32'(m_a[16]));
        check("b_12k",   32'(if_b.clk_12KHz_en), 32'(strobe_at(cyc_b, DIV_B)));
        check("b_6k",    32'(if_b.clk_6KHz_en),  32'(strobe_at(cyc_b, 2 * DIV_B)));
        check("b_lfsr",  32'(if_b.lfsr),         32'(m_b));
        check("b_noise", 32'(if_b.noise),        32'(m_b[16]));
    endtask

    // One clock: randomise B, advance the model on the rising edge, compare on the falling edge.
    task automatic step_cycle();
        if_b.noise_en = ($urandom_range(0, 9) != 0);
        if_b.load     = ($urandom_range(0, 49) == 0);
        if_b.seed_in  = ($urandom_range(0, 3) == 0) ? '0 : lfsr_t'($urandom);
        @(posedge clk);
        m_a = ref_next(m_a, if_a.load, if_a.seed_in, strobe_at(cyc_a, DIV_A), if_a.noise_en);
        m_b = ref_next(m_b, if_b.load, if_b.seed_in, strobe_at(cyc_b, DIV_B), if_b.noise_en);
        cyc_a++;
        cyc_b++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to(input int target);
        while (cyc_a < target) step_cycle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a12"},   32'(if_a.clk_12KHz_en), 0);
        check({tag, "_a6"},    32'(if_a.clk_6KHz_en),  0);
        check({tag, "_alfsr"}, 32'(if_a.lfsr),         32'(SEED));
        check({tag, "_anz"},   32'(if_a.noise),        32'(SEED[16]));
        check({tag, "_b12"},   32'(if_b.clk_12KHz_en), 0);
        check({tag, "_blfsr"}, 32'(if_b.lfsr),         32'(SEED));
    endtask

    initial begin
        if_a.noise_en = 1'b1;
        if_a.load     = 1'b0;
        if_a.seed_in  = '0;
        if_b.noise_en = 1'b1;
        if_b.load     = 1'b0;
        if_b.seed_in  = '0;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // First strobes from reset release.
        run_to(DIV_A - 1);
        check("pre_12k", 32'(if_a.clk_12KHz_en), 0);
        run_to(DIV_A);
        check("first_12k", 32'(if_a.clk_12KHz_en), 1);
        check("first_no6k", 32'(if_a.clk_6KHz_en), 0);
        run_to(DIV_A + 1);
        check("width_12k", 32'(if_a.clk_12KHz_en), 0);
        check("seed_step1", 32'(if_a.lfsr), 32'h1FFFE);
        run_to(2 * DIV_A);
        check("second_12k", 32'(if_a.clk_12KHz_en), 1);
        check("first_6k", 32'(if_a.clk_6KHz_en), 1);
        run_to(2 * DIV_A + 1);
        check("width_6k", 32'(if_a.clk_6KHz_en), 0);
        check("seed_step2", 32'(if_a.lfsr), 32'h1FFFC);

        // Hold across five strobes, then resume on the next one.
        if_a.noise_en = 1'b0;
        run_to(7 * DIV_A + 1);
        check("hold_5", 32'(if_a.lfsr), 32'h1FFFC);
        if_a.noise_en = 1'b1;
        run_to(8 * DIV_A + 1);
        check("resume", 32'(if_a.lfsr), 32'h1FFF8);

        // Load on a strobe cycle wins over the step.
        run_to(9 * DIV_A);
        check("load_on_strobe", 32'(if_a.clk_12KHz_en), 1);
        if_a.load    = 1'b1;
        if_a.seed_in = 17'h00001;
        step_cycle();
        if_a.load = 1'b0;
        check("load_wins", 32'(if_a.lfsr), 32'h00001);
        run_to(10 * DIV_A + 1);
        check("step_after_load", 32'(if_a.lfsr), 32'h00002);

        // All-zero load, then one strobe.
        if_a.load    = 1'b1;
        if_a.seed_in = 17'h00000;
        step_cycle();
        if_a.load = 1'b0;
        check("zero_loaded", 32'(if_a.lfsr), 32'h00000);
        run_to(11 * DIV_A + 1);
`ifdef NOISE_LOCKUP_GUARD_EN
        check("zero_guard", 32'(if_a.lfsr), 32'h1FFFF);
`else
        check("zero_stuck", 32'(if_a.lfsr), 32'h00000);
`endif

        // Asynchronous reset 500 cycles into a period.
        run_to(11 * DIV_A + 500);
        if_b.load = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        cyc_a = 0;
        cyc_b = 0;
        m_a   = SEED;
        m_b   = SEED;
        @(negedge clk);
        rst_n = 1'b1;
        run_to(DIV_A - 1);
        check("rst_pre_12k", 32'(if_a.clk_12KHz_en), 0);
        run_to(DIV_A);
        check("rst_first_12k", 32'(if_a.clk_12KHz_en), 1);

        // Extra random exercise of the fast instance.
        run_to(DIV_A + 6000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bzone_noise_source.md
# bzone_noise_source

Clock-enable generator and 17-bit noise LFSR for the BattleZone sound section. The block divides the system clock into single-cycle 12 kHz and 6 kHz enable strobes and steps a maximal-length LFSR on the 12 kHz strobe. Its `clk_6KHz_en` and `noise` outputs drive the clock-enable and J/K inputs of the downstream 74109-style flip-flop models and noise-shaping stages.

## Interface
- `CLK_HZ`, 12_096_000, system clock frequency.
- `NOISE_HZ`, 12_000, LFSR step rate; `DIV = CLK_HZ/NOISE_HZ` (1008 at defaults), must be ≥ 2.
- `SEED`, 17'h1FFFF, LFSR value after reset.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `noise_en`  in  1  1 = LFSR steps on the 12 kHz strobe; 0 = LFSR holds. Enables always run.
- `load`  in  1  synchronous seed load.
- `seed_in`  in  17  value loaded when `load`=1.
- `clk_12KHz_en`  out  1  one-cycle strobe, period DIV.
- `clk_6KHz_en`  out  1  one-cycle strobe on every second 12 kHz strobe.
- `noise`  out  1  LFSR bit 16.
- `lfsr`  out  17  full LFSR state.

## Operation
- Divider: `cnt` counts 0..DIV-1 and wraps to 0.
  - `clk_12KHz_en` is registered as `(cnt == DIV-1)`.
- Phase bit `ph` toggles on every `clk_12KHz_en` cycle.
  - `clk_6KHz_en` is registered as `(cnt == DIV-1) && ph`.
  - 6 kHz strobes therefore coincide with the 2nd, 4th, … 12 kHz strobes.
- LFSR is Fibonacci, polynomial x^17+x^14+1.
  - Step: `lfsr <= {lfsr[15:0], lfsr[16]^lfsr[13]}`.
- LFSR update priority, per edge:
  1. `load`=1: `lfsr <= seed_in`, regardless of strobe or `noise_en`.
  2. Else, `clk_12KHz_en`=1 and `noise_en`=1: step.
  3. Else: hold.
- `noise = lfsr[16]`, combinational from the register.
- Reset values:
  - `cnt`=0, `ph`=0.
  - Both strobes 0.
  - `lfsr`=SEED, so `noise`=SEED[16].
- Reset asserted mid-count returns all state to reset values immediately (asynchronous). No partial strobe is produced.
- `load` asserted on a strobe cycle: the load wins and that step is lost. The divider and `ph` are unaffected.

## Timing
- Counting from reset release:
  - First `clk_12KHz_en` is high during cycle DIV (after the DIV-th rising edge).
  - Subsequent 12 kHz strobes are exactly DIV cycles apart.
- First `clk_6KHz_en` arrives at cycle 2·DIV; period is 2·DIV.
- Each strobe is exactly one cycle wide. The two strobes are never misaligned.
- `lfsr`/`noise` change on the edge that ends a strobe cycle, i.e. 1-cycle latency from the strobe.
- `load` takes effect on the next edge (1-cycle latency).
- Without `load`, the LFSR sequence period is 131071 steps.

## Configuration
- `NOISE_LOCKUP_GUARD_EN` defined:
  - If a step is due while `lfsr == 0`, the register reloads SEED instead of stepping.
  - Loading 0 therefore recovers at the next step.
- Not defined:
  - No check. An all-zero state persists until `load` or reset.
  - Guard logic is absent from the netlist.

## Structure
- Shared sound package holds:
  - `LFSR_W = 17`
  - tap constants `TAP_HI = 16`, `TAP_LO = 13`
  - default `CLK_HZ`
  - typedef `lfsr_t` (logic [16:0])
- One sub-module, `bzone_clk_en_div`, implements the counter, `ph`, and both strobes. It is parameterised by DIV and reused by other sound stages.
- The LFSR and the optional guard stay in the top module.

## Test plan
- Reset release, DIV=1008:
  - First `clk_12KHz_en` at cycle 1008, next at 2016.
  - `clk_6KHz_en` only at 2016, 4032.
  - Both strobes exactly 1 cycle wide.
- Default seed with `noise_en`=1:
  - After 1st strobe, `lfsr`=17'h1FFFE; after 2nd, 17'h1FFFC.
  - After 131071 strobes, `lfsr`=17'h1FFFF again.
- `noise_en`=0 across 5 strobes → `lfsr` unchanged; re-enable → stepping resumes on the next strobe.
- `load`=1 with `seed_in`=17'h00001 on a strobe cycle → `lfsr`=17'h00001 next cycle, no step that cycle.
- Load 17'h00000, then wait one strobe:
  - With `NOISE_LOCKUP_GUARD_EN`, `lfsr`=17'h1FFFF.
  - Without it, `lfsr` stays 0.
- `rst_n` pulsed low at cycle 500 of a period → all outputs at reset values immediately; next `clk_12KHz_en` 1008 cycles after release.
